// File: rtl/bus_arbiter.sv
// Two-client arbiter sharing one external memory bus between the instruction
// fetcher (i-side) and the data-memory stage (d-side); one owner per transaction.
module bus_arbiter #(
  parameter int unsigned BUS_DATA_WIDTH = 64,
  parameter int unsigned BUS_TAG_WIDTH  = 13
) (
  input  logic                      clk,
  input  logic                      reset,

  input  logic [BUS_DATA_WIDTH-1:0] ibus_req,
  input  logic                      ibus_reqcyc,
  input  logic [BUS_TAG_WIDTH-1:0]  ibus_reqtag,
  input  logic                      ibus_respack,
  output logic                      ibus_respcyc,
  output logic [BUS_DATA_WIDTH-1:0] ibus_resp,
  output logic [BUS_TAG_WIDTH-1:0]  ibus_resptag,

  input  logic [BUS_DATA_WIDTH-1:0] dbus_req,
  input  logic                      dbus_reqcyc,
  input  logic [BUS_TAG_WIDTH-1:0]  dbus_reqtag,
  input  logic                      dbus_respack,
  output logic                      dbus_respcyc,
  output logic [BUS_DATA_WIDTH-1:0] dbus_resp,
  output logic [BUS_TAG_WIDTH-1:0]  dbus_resptag,

  output logic [BUS_DATA_WIDTH-1:0] bus_req,
  output logic                      bus_reqcyc,
  output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
  input  logic                      bus_reqack,
  input  logic                      bus_respcyc,
  input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
  input  logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
  output logic                      bus_respack
);

  typedef enum logic [2:0] {StIdle, StIReq, StIResp, StDReq, StDResp} state_e;

  localparam logic LastI = 1'b0;
  localparam logic LastD = 1'b1;

  state_e state_q;
  logic   last_q;
  logic   seen_q;

  // Tag MSB marks a write: no response phase, beats accepted while reqcyc is held.
  logic i_is_write, d_is_write;
  assign i_is_write = ibus_reqtag[BUS_TAG_WIDTH-1];
  assign d_is_write = dbus_reqtag[BUS_TAG_WIDTH-1];

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StIdle;
      last_q  <= LastI;
      seen_q  <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          // On a tie the client that was not granted last wins.
          if (dbus_reqcyc && (!ibus_reqcyc || last_q == LastI)) begin
            state_q <= StDReq;
            last_q  <= LastD;
          end else if (ibus_reqcyc) begin
            state_q <= StIReq;
            last_q  <= LastI;
          end
        end
        StIReq: begin
          if (!ibus_reqcyc) begin
            state_q <= StIdle;
          end else if (bus_reqack && !i_is_write) begin
            state_q <= StIResp;
          end
        end
        StDReq: begin
          if (!dbus_reqcyc) begin
            state_q <= StIdle;
          end else if (bus_reqack && !d_is_write) begin
            state_q <= StDResp;
          end
        end
        StIResp, StDResp: begin
          // Burst ends on the first idle bus cycle after at least one beat.
          if (bus_respcyc) begin
            seen_q <= 1'b1;
          end else if (seen_q) begin
            seen_q  <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: begin
          state_q <= StIdle;
          seen_q  <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    bus_req      = '0;
    bus_reqcyc   = 1'b0;
    bus_reqtag   = '0;
    bus_respack  = 1'b0;
    ibus_respcyc = 1'b0;
    ibus_resp    = '0;
    ibus_resptag = '0;
    dbus_respcyc = 1'b0;
    dbus_resp    = '0;
    dbus_resptag = '0;
    case (state_q)
      StIReq: begin
        bus_req    = ibus_req;
        bus_reqcyc = ibus_reqcyc;
        bus_reqtag = ibus_reqtag;
      end
      StDReq: begin
        bus_req    = dbus_req;
        bus_reqcyc = dbus_reqcyc;
        bus_reqtag = dbus_reqtag;
      end
      StIResp: begin
        ibus_respcyc = bus_respcyc;
        ibus_resp    = bus_resp;
        ibus_resptag = bus_resptag;
        bus_respack  = ibus_respack;
      end
      StDResp: begin
        dbus_respcyc = bus_respcyc;
        dbus_resp    = bus_resp;
        dbus_resptag = bus_resptag;
        bus_respack  = dbus_respack;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed self-checking bench for bus_arbiter: reads, ties, writes, late
// arrival, respack passthrough and reset mid-burst.
module tb_bus_arbiter;

  localparam int unsigned DW = 64;
  localparam int unsigned TW = 13;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] ibus_req, dbus_req, bus_resp;
  logic          ibus_reqcyc, dbus_reqcyc, ibus_respack, dbus_respack;
  logic [TW-1:0] ibus_reqtag, dbus_reqtag, bus_resptag;
  logic          bus_reqack, bus_respcyc;
  logic          ibus_respcyc, dbus_respcyc, bus_reqcyc, bus_respack;
  logic [DW-1:0] ibus_resp, dbus_resp, bus_req;
  logic [TW-1:0] ibus_resptag, dbus_resptag, bus_reqtag;

  int tests = 0;
  int fails = 0;

  bus_arbiter #(.BUS_DATA_WIDTH(DW), .BUS_TAG_WIDTH(TW)) dut (
    .clk          (clk),
    .reset        (reset),
    .ibus_req     (ibus_req),
    .ibus_reqcyc  (ibus_reqcyc),
    .ibus_reqtag  (ibus_reqtag),
    .ibus_respack (ibus_respack),
    .ibus_respcyc (ibus_respcyc),
    .ibus_resp    (ibus_resp),
    .ibus_resptag (ibus_resptag),
    .dbus_req     (dbus_req),
    .dbus_reqcyc  (dbus_reqcyc),
    .dbus_reqtag  (dbus_reqtag),
    .dbus_respack (dbus_respack),
    .dbus_respcyc (dbus_respcyc),
    .dbus_resp    (dbus_resp),
    .dbus_resptag (dbus_resptag),
    .bus_req      (bus_req),
    .bus_reqcyc   (bus_reqcyc),
    .bus_reqtag   (bus_reqtag),
    .bus_reqack   (bus_reqack),
    .bus_respcyc  (bus_respcyc),
    .bus_resp     (bus_resp),
    .bus_resptag  (bus_resptag),
    .bus_respack  (bus_respack)
  );

  always #5 clk = ~clk;

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".bus_reqcyc"}, 64'(bus_reqcyc), 64'd0);
    chk({tag, ".bus_req"}, bus_req, 64'd0);
    chk({tag, ".bus_reqtag"}, 64'(bus_reqtag), 64'd0);
    chk({tag, ".bus_respack"}, 64'(bus_respack), 64'd0);
    chk({tag, ".ibus_respcyc"}, 64'(ibus_respcyc), 64'd0);
    chk({tag, ".ibus_resp"}, ibus_resp, 64'd0);
    chk({tag, ".dbus_respcyc"}, 64'(dbus_respcyc), 64'd0);
    chk({tag, ".dbus_resptag"}, 64'(dbus_resptag), 64'd0);
  endtask

  initial begin
    reset = 1'b0;
    ibus_req = '0; ibus_reqcyc = 1'b0; ibus_reqtag = '0; ibus_respack = 1'b0;
    dbus_req = '0; dbus_reqcyc = 1'b0; dbus_reqtag = '0; dbus_respack = 1'b0;
    bus_reqack = 1'b0; bus_respcyc = 1'b0; bus_resp = '0; bus_resptag = '0;
    next();
    next();
    reset = 1'b1;
    // Bus noise in IDLE must not leak to anyone.
    bus_respcyc = 1'b1; bus_resp = 64'hDEAD; bus_resptag = 13'h7;
    ibus_respack = 1'b1; dbus_respack = 1'b1;
    settle();
    chk_all_zero("reset");
    bus_respcyc = 1'b0; bus_resp = '0; bus_resptag = '0;
    ibus_respack = 1'b0; dbus_respack = 1'b0;

    // ---- single i read, 8 beats ----
    ibus_reqcyc = 1'b1; ibus_req = 64'h1000; ibus_reqtag = 13'h0001;
    settle();
    chk("iread.no_grant_yet", 64'(bus_reqcyc), 64'd0);
    next();
    chk("iread.bus_reqcyc", 64'(bus_reqcyc), 64'd1);
    chk("iread.bus_req", bus_req, 64'h1000);
    chk("iread.bus_reqtag", 64'(bus_reqtag), 64'h1);
    bus_reqack = 1'b1;
    next();
    bus_reqack = 1'b0;
    settle();
    chk("iread.resp_reqcyc", 64'(bus_reqcyc), 64'd0);
    for (int b = 0; b < 8; b++) begin
      bus_respcyc = 1'b1; bus_resp = 64'hA000 + 64'(b); bus_resptag = 13'h0001;
      ibus_respack = 1'b1;
      settle();
      chk("iread.ibus_respcyc", 64'(ibus_respcyc), 64'd1);
      chk("iread.ibus_resp", ibus_resp, 64'hA000 + 64'(b));
      chk("iread.ibus_resptag", 64'(ibus_resptag), 64'h1);
      chk("iread.dbus_respcyc", 64'(dbus_respcyc), 64'd0);
      chk("iread.bus_respack", 64'(bus_respack), 64'd1);
      next();
    end
    bus_respcyc = 1'b0; bus_resp = '0; bus_resptag = '0;
    ibus_respack = 1'b0; ibus_reqcyc = 1'b0;
    settle();
    chk("iread.end_respcyc", 64'(ibus_respcyc), 64'd0);
    next();
    // IDLE now: a fresh d request must be granted on the following edge.
    dbus_reqcyc = 1'b1; dbus_req = 64'h7700; dbus_reqtag = 13'h0009;
    settle();
    chk_all_zero("iread.idle");
    next();
    chk("iread.idle_regrant", bus_req, 64'h7700);
    dbus_reqcyc = 1'b0;  // abandon before any reqack
    settle();
    chk("abandon.reqcyc_follows", 64'(bus_reqcyc), 64'd0);
    next();
    settle();
    chk_all_zero("abandon.idle");

    // ---- simultaneous requests right after reset ----
    reset = 1'b0;
    next();
    reset = 1'b1;
    ibus_reqcyc = 1'b1; ibus_req = 64'h2000; ibus_reqtag = 13'h0002;
    dbus_reqcyc = 1'b1; dbus_req = 64'h3000; dbus_reqtag = 13'h0003;
    next();
    chk("tie1.d_first", bus_req, 64'h3000);
    chk("tie1.tag", 64'(bus_reqtag), 64'h3);
    bus_reqack = 1'b1;
    next();
    bus_reqack = 1'b0;
    for (int b = 0; b < 2; b++) begin
      bus_respcyc = 1'b1; bus_resp = 64'hC000 + 64'(b); bus_resptag = 13'h0003;
      settle();
      chk("tie1.dbus_resp", dbus_resp, 64'hC000 + 64'(b));
      chk("tie1.ibus_respcyc", 64'(ibus_respcyc), 64'd0);
      next();
    end
    bus_respcyc = 1'b0; bus_resp = '0; bus_resptag = '0;
    next();
    // IDLE with both still requesting: last was d, so i wins this tie.
    next();
    chk("tie2.i_wins", bus_req, 64'h2000);
    chk("tie2.reqcyc", 64'(bus_reqcyc), 64'd1);
    bus_reqack = 1'b1;
    next();
    bus_reqack = 1'b0;
    bus_respcyc = 1'b1; bus_resp = 64'hE000; bus_resptag = 13'h0002;
    settle();
    chk("tie2.ibus_resp", ibus_resp, 64'hE000);
    chk("tie2.dbus_respcyc", 64'(dbus_respcyc), 64'd0);
    next();
    bus_respcyc = 1'b0; bus_resp = '0; bus_resptag = '0;
    ibus_reqcyc = 1'b0;
    next();
    next();
    chk("tie2.d_after_i", bus_req, 64'h3000);
    dbus_reqcyc = 1'b0;
    next();

    // ---- d write, 8 beats, no response phase ----
    dbus_reqcyc = 1'b1; dbus_reqtag = 13'h1000; dbus_req = 64'hB000;
    dbus_respack = 1'b1;
    next();
    for (int b = 0; b < 8; b++) begin
      dbus_req = 64'hB000 + 64'(b);
      bus_reqack = 1'b1;
      bus_respcyc = 1'b1; bus_resp = 64'h5555;
      settle();
      chk("write.bus_req", bus_req, 64'hB000 + 64'(b));
      chk("write.bus_reqtag", 64'(bus_reqtag), 64'h1000);
      chk("write.no_resp", 64'(dbus_respcyc), 64'd0);
      chk("write.no_respack", 64'(bus_respack), 64'd0);
      next();
    end
    bus_reqack = 1'b0; bus_respcyc = 1'b0; bus_resp = '0;
    dbus_reqcyc = 1'b0; dbus_respack = 1'b0;
    settle();
    chk("write.end_reqcyc", 64'(bus_reqcyc), 64'd0);
    next();
    settle();
    chk_all_zero("write.idle");

    // ---- late i arrival during d response, with d respack toggling ----
    dbus_reqcyc = 1'b1; dbus_req = 64'h4000; dbus_reqtag = 13'h0004;
    next();
    bus_reqack = 1'b1;
    next();
    bus_reqack = 1'b0;
    ibus_reqcyc = 1'b1; ibus_req = 64'h5000; ibus_reqtag = 13'h0005;
    ibus_respack = 1'b1;
    for (int b = 0; b < 4; b++) begin
      bus_respcyc = 1'b1; bus_resp = 64'hF000 + 64'(b); bus_resptag = 13'h0004;
      dbus_respack = b[0];
      settle();
      chk("late.bus_reqcyc", 64'(bus_reqcyc), 64'd0);
      chk("late.ibus_respcyc", 64'(ibus_respcyc), 64'd0);
      chk("late.dbus_respcyc", 64'(dbus_respcyc), 64'd1);
      chk("late.respack", 64'(bus_respack), 64'(b[0]));
      next();
    end
    bus_respcyc = 1'b0; bus_resp = '0; bus_resptag = '0;
    dbus_reqcyc = 1'b0; dbus_respack = 1'b0;
    next();
    dbus_respack = 1'b1;  // must be ignored outside D_RESP
    settle();
    chk("late.idle_reqcyc", 64'(bus_reqcyc), 64'd0);
    chk("late.idle_respack", 64'(bus_respack), 64'd0);
    next();
    chk("late.i_granted", bus_req, 64'h5000);
    chk("late.i_reqcyc", 64'(bus_reqcyc), 64'd1);
    dbus_respack = 1'b0;

    // ---- reset during beat 3 of an i response ----
    bus_reqack = 1'b1;
    next();
    bus_reqack = 1'b0;
    for (int b = 0; b < 4; b++) begin
      bus_respcyc = 1'b1; bus_resp = 64'h9000 + 64'(b); bus_resptag = 13'h0005;
      if (b == 3) reset = 1'b0;
      settle();
      chk("rst.beat_fwd", ibus_resp, 64'h9000 + 64'(b));
      next();
    end
    reset = 1'b1;
    settle();
    chk_all_zero("rst.after");
    bus_respcyc = 1'b0; bus_resp = '0; bus_resptag = '0;
    ibus_reqcyc = 1'b0; ibus_respack = 1'b0;
    next();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
